// File: rtl/led_matrix_scan_pkg.sv
// rtl/led_matrix_scan_pkg.sv - shared types and constants for the LED matrix scan generator
package led_matrix_scan_pkg;

    localparam int BRIGHTNESS_BITS = 6;
    localparam int ROW_ADDR_BITS   = 4;
    localparam int PLANE_BITS      = 3;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_LATCH   = 2'd1,
        ST_GUARD   = 2'd2,
        ST_DISPLAY = 2'd3
    } scan_state_t;

    // One-hot bitplane selector for a bitplane index.
    function automatic logic [BRIGHTNESS_BITS-1:0] plane_to_mask(input logic [PLANE_BITS-1:0] p);
        return BRIGHTNESS_BITS'(1) << p;
    endfunction

endpackage

// File: rtl/led_matrix_scan_bcm_timer.sv
// rtl/led_matrix_scan_bcm_timer.sv - bcm_display_timer: counts BASE_CYCLES<<plane display cycles
module bcm_display_timer
    import led_matrix_scan_pkg::*;
#(
    parameter int  BASE_CYCLES = 1,
    localparam int CW          = $clog2(BASE_CYCLES * 32 + 1)
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  load,
    input  logic [PLANE_BITS-1:0] plane,
    input  logic                  tick,
    output logic                  done
);

    // Remaining display cycles after the current one; zero marks the last cycle.
    logic [CW-1:0] count;

    // Load the weighted duration minus one, then count down once per display cycle.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= (CW'(BASE_CYCLES) << plane) - CW'(1);
        end else if (tick && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - HUB75 BCM scan-timing generator; MATRIX_SCAN_GUARD_EN adds 2 blanking cycles after latch
module led_matrix_scan
    import led_matrix_scan_pkg::*;
#(
    parameter int  PIXEL_WIDTH              = 64,
    parameter int  PIXEL_HALFHEIGHT         = 16,
    parameter int  BRIGHTNESS_BASE_CYCLES   = 1,
    localparam int _NUM_COLUMN_ADDRESS_BITS = $clog2(PIXEL_WIDTH)
) (
    input  logic                                clk_in,
    input  logic                                reset,
    output logic [_NUM_COLUMN_ADDRESS_BITS-1:0] column_address,
    output logic [ROW_ADDR_BITS-1:0]            row_address,
    output logic [ROW_ADDR_BITS-1:0]            row_address_active,
    output logic                                clk_pixel_load,
    output logic                                clk_pixel,
    output logic                                row_latch,
    output logic                                output_enable,
    output logic [BRIGHTNESS_BITS-1:0]          brightness_mask
);

    localparam logic [_NUM_COLUMN_ADDRESS_BITS-1:0] LAST_COL   = _NUM_COLUMN_ADDRESS_BITS'(PIXEL_WIDTH - 1);
    localparam logic [ROW_ADDR_BITS-1:0]            LAST_ROW   = ROW_ADDR_BITS'(PIXEL_HALFHEIGHT - 1);
    localparam logic [PLANE_BITS-1:0]               LAST_PLANE = PLANE_BITS'(BRIGHTNESS_BITS - 1);

    // The state/counter registers name the position emitted on the next edge;
    // the output registers show the position of the current cycle.
    scan_state_t                         state;
    logic                                phase;
    logic [_NUM_COLUMN_ADDRESS_BITS-1:0] col_cnt;
    logic [ROW_ADDR_BITS-1:0]            row_cnt;
    logic [PLANE_BITS-1:0]               plane;
    logic                                timer_done;
`ifdef MATRIX_SCAN_GUARD_EN
    logic                                guard_cnt;
`endif

    bcm_display_timer #(
        .BASE_CYCLES (BRIGHTNESS_BASE_CYCLES)
    ) u_timer (
        .clk_in (clk_in),
        .reset  (reset),
        .load   (state == ST_LATCH),
        .plane  (plane),
        .tick   (state == ST_DISPLAY),
        .done   (timer_done)
    );

    // Scan FSM: emit registered panel signals for the current position, then advance.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state              <= ST_LOAD;
            phase              <= 1'b0;
            col_cnt            <= '0;
            row_cnt            <= '0;
            plane              <= '0;
`ifdef MATRIX_SCAN_GUARD_EN
            guard_cnt          <= 1'b0;
`endif
            column_address     <= '0;
            row_address        <= '0;
            row_address_active <= '0;
            clk_pixel_load     <= 1'b0;
            clk_pixel          <= 1'b0;
            row_latch          <= 1'b0;
            output_enable      <= 1'b0;
            brightness_mask    <= BRIGHTNESS_BITS'(1);
        end else begin
            clk_pixel_load  <= 1'b0;
            clk_pixel       <= 1'b0;
            row_latch       <= 1'b0;
            output_enable   <= 1'b0;
            column_address  <= col_cnt;
            row_address     <= row_cnt;
            brightness_mask <= plane_to_mask(plane);
            // The displayed row follows the loaded row on the edge that ends the latch pulse.
            if (row_latch) begin
                row_address_active <= row_address;
            end
            case (state)
                ST_LOAD: begin
                    if (!phase) begin
                        clk_pixel_load <= 1'b1;
                        phase          <= 1'b1;
                    end else begin
                        clk_pixel <= 1'b1;
                        phase     <= 1'b0;
                        if (col_cnt == LAST_COL) begin
                            col_cnt <= '0;
                            state   <= ST_LATCH;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    row_latch <= 1'b1;
`ifdef MATRIX_SCAN_GUARD_EN
                    guard_cnt <= 1'b0;
                    state     <= ST_GUARD;
`else
                    state     <= ST_DISPLAY;
`endif
                end
`ifdef MATRIX_SCAN_GUARD_EN
                ST_GUARD: begin
                    guard_cnt <= ~guard_cnt;
                    if (guard_cnt) begin
                        state <= ST_DISPLAY;
                    end
                end
`endif
                ST_DISPLAY: begin
                    output_enable <= 1'b1;
                    if (timer_done) begin
                        state <= ST_LOAD;
                        if (plane == LAST_PLANE) begin
                            plane   <= '0;
                            row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
                        end else begin
                            plane <= plane + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb/tb_led_matrix_scan.sv - directed self-checking bench for led_matrix_scan
module tb_led_matrix_scan;

    localparam int W    = 64;
    localparam int HH   = 16;
    localparam int BASE = 1;
`ifdef MATRIX_SCAN_GUARD_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif
    localparam int SEG   = 2 * W + 1 + G;
    localparam int ROW_P = 6 * SEG + 63 * BASE;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic [5:0] column_address;
    logic [3:0] row_address;
    logic [3:0] row_address_active;
    logic       clk_pixel_load;
    logic       clk_pixel;
    logic       row_latch;
    logic       output_enable;
    logic [5:0] brightness_mask;

    led_matrix_scan #(
        .PIXEL_WIDTH            (W),
        .PIXEL_HALFHEIGHT       (HH),
        .BRIGHTNESS_BASE_CYCLES (BASE)
    ) dut (
        .clk_in             (clk_in),
        .reset              (reset),
        .column_address     (column_address),
        .row_address        (row_address),
        .row_address_active (row_address_active),
        .clk_pixel_load     (clk_pixel_load),
        .clk_pixel          (clk_pixel),
        .row_latch          (row_latch),
        .output_enable      (output_enable),
        .brightness_mask    (brightness_mask)
    );

    always #5 clk_in = ~clk_in;

    int         total   = 0;
    int         bad     = 0;
    int         cyc     = -1;
    int         run_len = 0;
    int         overlap = 0;
    int         runs[$];
    logic [5:0] run_mask[$];
    logic [5:0] cur_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
        if (output_enable && row_latch) overlap++;
        if (output_enable) begin
            if (run_len == 0) cur_mask = brightness_mask;
            run_len++;
        end else if (run_len > 0) begin
            runs.push_back(run_len);
            run_mask.push_back(cur_mask);
            run_len = 0;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        int pix_edges;
        int col_bad;
        int latch_cnt;
        int oe_cnt;
        int both_cnt;
        logic prev_pix;
        int t;

        repeat (3) @(negedge clk_in);
        chk("rst_oe", output_enable, 0);
        chk("rst_load", clk_pixel_load, 0);
        chk("rst_pixel", clk_pixel, 0);
        chk("rst_latch", row_latch, 0);
        chk("rst_mask", brightness_mask, 6'b000001);
        chk("rst_row", row_address, 0);
        chk("rst_active", row_address_active, 0);
        chk("rst_col", column_address, 0);

        reset = 1'b0;
        step();
        chk("c0_load", clk_pixel_load, 1);
        chk("c0_col", column_address, 0);
        chk("c0_mask", brightness_mask, 6'b000001);
        chk("c0_oe", output_enable, 0);
        chk("c0_pixel", clk_pixel, 0);

        pix_edges = 0; col_bad = 0; latch_cnt = 0; oe_cnt = 0; both_cnt = 0;
        prev_pix = 1'b0;
        for (int c = 0; c < 2 * W; c++) begin
            if (c > 0) step();
            if (clk_pixel && !prev_pix) begin
                if (column_address != 6'(pix_edges)) col_bad++;
                pix_edges++;
            end
            prev_pix = clk_pixel;
            if (row_latch) latch_cnt++;
            if (output_enable) oe_cnt++;
            if (clk_pixel && clk_pixel_load) both_cnt++;
        end
        chk("load_pix_edges", pix_edges, W);
        chk("load_col_seq_err", col_bad, 0);
        chk("load_latch", latch_cnt, 0);
        chk("load_oe", oe_cnt, 0);
        chk("load_pix_and_fetch", both_cnt, 0);

        step();
        chk("latch_cycle", row_latch, 1);
        chk("latch_oe", output_enable, 0);
        chk("latch_pixel", clk_pixel, 0);
        chk("latch_col_wrap", column_address, 0);

        step();
        chk("post_latch_oe", output_enable, (G == 0) ? 1 : 0);
        chk("post_latch_latch", row_latch, 0);
        run_to(2 * W + 1 + G);
        chk("first_display_oe", output_enable, 1);

        run_to(ROW_P - 1);
        chk("row0_end_row", row_address, 0);
        step();
        chk("row1_row", row_address, 1);
        chk("row1_load", clk_pixel_load, 1);
        chk("row1_mask", brightness_mask, 6'b000001);
        chk("row1_col", column_address, 0);
        chk("run_count_row0", runs.size(), 6);
        if (runs.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("run_len_%0d", i), runs[i], BASE << i);
                chk($sformatf("run_mask_%0d", i), run_mask[i], 1 << i);
            end
        end

        run_to(ROW_P + 2 * W);
        chk("row1_latch", row_latch, 1);
        chk("row1_active_before", row_address_active, 0);
        step();
        chk("row1_active_after", row_address_active, 1);

        run_to(5 * ROW_P);
        chk("row5_row", row_address, 5);
        chk("row5_active_lag", row_address_active, 4);

        run_to(16 * ROW_P - 1);
        chk("row15_row", row_address, 15);
        step();
        chk("frame_wrap_row", row_address, 0);
        chk("frame_wrap_active", row_address_active, 15);
        chk("frame_run_count", runs.size(), 96);
        chk("latch_oe_overlap", overlap, 0);

        t = 16 * ROW_P + 5 * ROW_P + 6 * SEG + 31 * BASE + 5;
        run_to(t);
        chk("mid_oe", output_enable, 1);
        chk("mid_row", row_address, 5);
        chk("mid_mask", brightness_mask, 6'b100000);

        #2 reset = 1'b1;
        #1;
        chk("async_oe", output_enable, 0);
        chk("async_row", row_address, 0);
        chk("async_mask", brightness_mask, 6'b000001);
        chk("async_active", row_address_active, 0);
        @(negedge clk_in);
        reset = 1'b0;
        step();
        chk("restart_load", clk_pixel_load, 1);
        chk("restart_col", column_address, 0);
        chk("restart_row", row_address, 0);
        chk("restart_mask", brightness_mask, 6'b000001);
        chk("restart_oe", output_enable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
